instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the RISC-V core, directly upstream of the main decoder. Holds the PC register, issues word requests to instruction memory over a req/gnt/rvalid interface, buffers returned instructions with their PCs in a small FIFO, and presents them to decode under a valid/ready handshake. Decode and branch resolution redirect fetch via `PCSrc`; `op` feeds the main decoder directly.

## Interface
- `WIDTH`, 32: address and instruction width.
- `RESET_PC`, 32'hBFC0_0000: first fetch address after reset.
- `DEPTH`, 2: instruction buffer entries (power of two, ≥2).

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `PCSrc` in 1: redirect pulse (taken branch).
- `BranchPC` in WIDTH: PC of the branch instruction.
- `ImmExt` in WIDTH: sign-extended branch offset.
- `imem_req` out 1: fetch request.
- `imem_addr` out WIDTH: word-aligned fetch address.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: read data valid. Asserted exactly 1 cycle after the accepting `gnt`.
- `imem_rdata` in WIDTH: instruction word.
- `Instr` out WIDTH: head-of-buffer instruction.
- `PC` out WIDTH: PC of `Instr`.
- `op` out 7: `Instr[6:0]`.
- `InstrValid` out 1: `Instr`/`PC` valid.
- `InstrReady` in 1: decode accepts this cycle.

## Operation
- Registers:
  - `fetch_pc`: next address to request.
  - FIFO of {pc, instr}, with `count` 0..DEPTH.
  - FSM: IDLE (nothing outstanding), WAIT (one request outstanding), DISCARD (outstanding request killed by a redirect).
- At most one request outstanding.
- `pop` = `InstrValid & InstrReady`.
- `imem_req` = `!PCSrc && (state==IDLE || (state==WAIT && imem_rvalid)) && (count − pop + (state==WAIT)) < DEPTH`.
  - In DISCARD, `req` is only allowed in the cycle its `rvalid` arrives, and that response does not count toward occupancy.
- `imem_addr` = `fetch_pc`. On `req & gnt`: `fetch_pc += 4` (mod 2^WIDTH, wraps silently); FSM → WAIT.
- Memory may see `req` withdrawn without a `gnt`. `addr` may change only while `req` is low.
- WAIT with `rvalid` and no new grant → IDLE. The response is pushed as {pc of request, rdata}.
- Redirect (`PCSrc`=1):
  - `fetch_pc` ← `(BranchPC + ImmExt) & ~3`.
  - FIFO flushed (`count` ← 0).
  - WAIT → DISCARD.
  - Any `rvalid` in the same cycle is dropped.
  - `pop` ignored that cycle.
- DISCARD: the next `rvalid` is dropped, then → IDLE, or → WAIT if a new grant occurs that cycle.
- A redirect in DISCARD stays in DISCARD and updates `fetch_pc`.
- Push and pop in the same cycle are both honoured. A push is never issued into a full FIFO; the issue rule guarantees this.
- `InstrValid` = `count != 0` (see Configuration for bypass).
- Reset:
  - `fetch_pc`=RESET_PC, `count`=0, FSM=IDLE.
  - `imem_req`=0 while `rst_n` low; `InstrValid`=0.
  - `Instr`=0, `PC`=RESET_PC, `op`=0 while empty.
- Reset asserted mid-operation discards everything immediately. An `rvalid` arriving after reset release that belongs to a pre-reset request is not expected; memory must be reset together with this block.

## Timing
- First `imem_req` is in the first cycle after `rst_n` deasserts, with `addr`=RESET_PC.
- Grant at cycle t → `rvalid` at t+1 → `InstrValid` at t+2 (t+1 with bypass).
- Sustained throughput is 1 instruction/cycle when `gnt` and `InstrReady` are held high.
- Redirect at cycle r: `InstrValid`=0 at r+1. New `req` at r+1 if IDLE, or in the `rvalid` cycle if DISCARD.
- All state is updated on the rising edge of `clk`. Outputs are driven from registers, except `imem_req` (combinational on `rvalid`, `PCSrc`, `InstrReady`).

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When `count`==0 and an accepted (non-discarded) `rvalid` arrives, `Instr`/`PC`/`InstrValid` present it combinationally that cycle.
  - If `InstrReady`, it is consumed and not pushed.
  - Bypass is suppressed in a `PCSrc` cycle.
- Undefined: every instruction passes through the FIFO, giving +1 cycle latency. Throughput is unchanged.

## Test plan
- Reset release, `gnt`/`rvalid` always 1, `InstrReady`=1 → `imem_addr` sequence BFC00000, BFC00004, …. `PC`/`Instr` match, first valid at cycle 2 (cycle 1 with bypass), one per cycle thereafter.
- Hold `InstrReady`=0 → exactly DEPTH instructions buffered, then `imem_req`=0. Release → no loss or duplication, order preserved.
- `PCSrc` with `BranchPC`=0xBFC00010, `ImmExt`=0xFFFFFFF8 while a request is outstanding → in-flight response dropped, FIFO empty, next `addr`=0xBFC00008.
- Redirect target 0x00000006 → `imem_addr`=0x00000004. `fetch_pc` at 0xFFFFFFFC, fetch → next `addr` 0x00000000.
- Random `gnt` stalls with a `PCSrc` pulse coinciding with `rvalid` → that instruction never appears on `Instr`.
- `rst_n` asserted asynchronously mid-burst → `InstrValid`=0 and `imem_req`=0 immediately; fetch resumes at RESET_PC after release.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, req/gnt/rvalid memory port, {pc,instr} buffer to decode.
// Optional FETCH_BYPASS_EN presents an accepted response combinationally when the buffer is empty.
module instr_fetch #(
  parameter int unsigned            WIDTH    = 32,
  parameter logic [WIDTH-1:0]       RESET_PC = WIDTH'(32'hBFC0_0000),
  parameter int unsigned            DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PCSrc,
  input  logic [WIDTH-1:0] BranchPC,
  input  logic [WIDTH-1:0] ImmExt,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] Instr,
  output logic [WIDTH-1:0] PC,
  output logic [6:0]       op,
  output logic             InstrValid,
  input  logic             InstrReady
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] req_pc;
  logic [WIDTH-1:0] fifo_pc    [DEPTH];
  logic [WIDTH-1:0] fifo_instr [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;

  logic             accept;
  logic             bypass;
  logic             fifo_valid;
  logic             pop;
  logic             fifo_pop;
  logic             push;
  logic             grant;
  logic             can_issue;
  logic [CW:0]      occupancy;
  logic [WIDTH-1:0] target_sum;

  assign fifo_valid = (count != '0);
  assign accept     = imem_rvalid && (state_q == S_WAIT) && !PCSrc;

`ifdef FETCH_BYPASS_EN
  assign bypass = accept && !fifo_valid;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    InstrValid = fifo_valid || bypass;
    Instr      = '0;
    PC         = RESET_PC;
    if (fifo_valid) begin
      Instr = fifo_instr[rd_ptr];
      PC    = fifo_pc[rd_ptr];
    end else if (bypass) begin
      Instr = imem_rdata;
      PC    = req_pc;
    end
  end

  assign op       = Instr[6:0];
  assign pop      = InstrValid && InstrReady && !PCSrc;
  assign fifo_pop = pop && fifo_valid;
  assign push     = accept && !(bypass && InstrReady);

  // Outstanding WAIT response counts as occupied; a DISCARD response never lands.
  assign occupancy = {1'b0, count} + (CW+1)'(state_q == S_WAIT) - (CW+1)'(pop);
  assign can_issue = (state_q == S_IDLE) || imem_rvalid;
  assign imem_req  = rst_n && !PCSrc && can_issue && (occupancy < (CW+1)'(DEPTH));
  assign grant     = imem_req && imem_gnt;
  assign imem_addr = fetch_pc;

  assign target_sum = BranchPC + ImmExt;

  // A redirect coinciding with the outstanding response retires it here, so
  // DISCARD is only entered while the response is still in flight.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)  state_d = grant ? S_WAIT : S_IDLE;
        else if (PCSrc)   state_d = S_DISCARD;
      end
      S_DISCARD: begin
        if (imem_rvalid)  state_d = grant ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (PCSrc)      fetch_pc <= {target_sum[WIDTH-1:2], 2'b00};
      else if (grant) fetch_pc <= fetch_pc + WIDTH'(4);
      if (grant)      req_pc   <= fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (PCSrc) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + AW'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !PCSrc) begin
      fifo_pc[wr_ptr]    <= req_pc;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: random memory stalls, decode stalls and redirects.
module tb_instr_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
`ifdef FETCH_BYPASS_EN
  localparam int          LAT      = 1;
`else
  localparam int          LAT      = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] BranchPC = '0;
  logic [31:0] ImmExt = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [6:0]  op;
  logic        InstrValid;
  logic        InstrReady = 1'b0;

  instr_fetch #(.WIDTH(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .BranchPC(BranchPC), .ImmExt(ImmExt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .Instr(Instr), .PC(PC), .op(op), .InstrValid(InstrValid), .InstrReady(InstrReady)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] model_pc = RESET_PC;
  int          tests = 0;
  int          fails = 0;

  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          gnt_pct = 100;
  int          rdy_pct = 100;
  int          redir_pct = 0;
  bit          force_redir = 0;
  logic [31:0] fr_b = '0;
  logic [31:0] fr_i = '0;
  bit          prev_redir = 0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive memory response and decode side, then grant, then update the model.
  task automatic step();
    @(negedge clk);
    imem_rvalid = pend;
    imem_rdata  = pend ? mem_word(pend_addr) : $urandom();
    PCSrc       = 1'b0;
    BranchPC    = $urandom();
    ImmExt      = $urandom();
    if (force_redir) begin
      PCSrc = 1'b1; BranchPC = fr_b; ImmExt = fr_i; force_redir = 0;
    end else if ($urandom_range(99) < redir_pct) begin
      PCSrc = 1'b1;
      case ($urandom_range(3))
        0: begin BranchPC = 32'hBFC0_0010; ImmExt = 32'hFFFF_FFF8; end
        1: begin BranchPC = 32'h0000_0000; ImmExt = 32'h0000_0006; end
        2: begin BranchPC = 32'hFFFF_FFF0; ImmExt = 32'h0000_000C; end
        default: begin BranchPC = $urandom(); ImmExt = 32'($signed(12'($urandom()))); end
      endcase
    end
    InstrReady = ($urandom_range(99) < rdy_pct);
    #1;
    if (prev_redir) chk("valid_after_redirect", 32'(InstrValid), 32'd0);
    imem_gnt = imem_req && ($urandom_range(99) < gnt_pct);
    if (imem_req && imem_gnt) begin
      chk("grant_addr", imem_addr, model_pc);
      q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
    end
    if (PCSrc) begin
      q.delete();
      model_pc = (BranchPC + ImmExt) & ~32'd3;
    end
    pend       = imem_req && imem_gnt;
    pend_addr  = imem_addr;
    prev_redir = PCSrc;
  endtask

  // Streaming after reset release: request at once, valid after LAT cycles, then every cycle.
  task automatic startup_check();
    gnt_pct = 100; rdy_pct = 100; redir_pct = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) begin
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RESET_PC);
      end
      chk("stream_valid", 32'(InstrValid), (c >= LAT) ? 32'd1 : 32'd0);
    end
  endtask

  // Monitor: every handshake pops the scoreboard; an empty head must read as zero/RESET_PC.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1) begin
        if (InstrValid && InstrReady && !PCSrc) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pop_unexpected: got pc %h instr %h, expected no instruction", PC, Instr);
          end else begin
            e = q.pop_front();
            chk("pop_pc", PC, e.pc);
            chk("pop_instr", Instr, e.instr);
            chk("pop_op", 32'(op), 32'(e.instr[6:0]));
          end
        end else if (!InstrValid) begin
          chk("empty_instr", Instr, 32'd0);
          chk("empty_pc", PC, RESET_PC);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_req", 32'(imem_req), 32'd0);
    chk("reset_valid", 32'(InstrValid), 32'd0);
    chk("reset_instr", Instr, 32'd0);
    chk("reset_pc", PC, RESET_PC);
    chk("reset_op", 32'(op), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    startup_check();

    // Decode stalled: exactly DEPTH instructions fetched, then requests stop.
    rdy_pct = 0; gnt_pct = 0;
    repeat (4) step();
    rdy_pct = 100;
    repeat (4) step();
    rdy_pct = 0; gnt_pct = 100;
    repeat (6) step();
    chk("full_count", 32'(q.size()), 32'(DEPTH));
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(InstrValid), 32'd1);
    rdy_pct = 100;
    repeat (4) step();

    // Drain, then redirect while a response is in flight.
    gnt_pct = 0;
    repeat (4) step();
    gnt_pct = 100;
    step();
    force_redir = 1; fr_b = 32'hBFC0_0010; fr_i = 32'hFFFF_FFF8;
    step();
    step();
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'hBFC0_0008);
    force_redir = 1; fr_b = 32'h0000_0000; fr_i = 32'h0000_0006;
    step();
    step();
    chk("align_addr", imem_addr, 32'h0000_0004);
    force_redir = 1; fr_b = 32'hFFFF_FFF0; fr_i = 32'h0000_000C;
    step();
    step();
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    gnt_pct = 60; rdy_pct = 70; redir_pct = 4;
    repeat (1500) step();

    // Asynchronous reset in the middle of a burst.
    gnt_pct = 100; rdy_pct = 100; redir_pct = 0;
    repeat (5) step();
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(imem_req), 32'd0);
    chk("async_rst_valid", 32'(InstrValid), 32'd0);
    imem_rvalid = 1'b0; imem_gnt = 1'b0; PCSrc = 1'b0;
    pend = 1'b0; prev_redir = 0;
    q.delete();
    model_pc = RESET_PC;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    startup_check();

    gnt_pct = 0; rdy_pct = 100;
    repeat (10) step();
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("drain_valid", 32'(InstrValid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
